multicycle_controller: RTL and testbench

//  Multicycle RISC-V control FSM; sits directly upstream of the ALU and drives its 3-bit ALUControl.

---
 rtl/riscv_ctrl_pkg.sv | 54 +++++
 rtl/alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 tb/tb_multicycle_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes,
// ALU operation codes and datapath mux select values.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IALU = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_SRA = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_READDATA  = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: maps ALUOp plus funct fields to ALUControl, flags bad funct.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alucontrol,
   output logic       illegal_funct
);

   always_comb begin
      alucontrol    = ALU_ADD;
      illegal_funct = 1'b0;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // op5 separates R-type (sub possible) from I-type addi, whose imm bit 30 is data
               3'b000: alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010: alucontrol = ALU_SLT;
               3'b100: alucontrol = ALU_XOR;
               3'b111: alucontrol = ALU_AND;
               3'b101: begin
                  if (funct7b5) alucontrol = ALU_SRA;
                  else          illegal_funct = 1'b1;
               end
               default: illegal_funct = 1'b1;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM driving datapath selects, write enables and ALUControl.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal op 2 cycles per instruction.
// Backpressure: none; one state per clock, write enables forced low while reset is high.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int STATE_W      = 4,
   parameter bit ILLEGAL_TRAP = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       illegal
);

   logic [STATE_W-1:0] state_r;
   state_t             state;
   state_t             state_n;
   logic [1:0]         aluop;
   logic               pcupdate, branch, irwrite_s, memwrite_s, regwrite_s, illegal_s;
   logic               illegal_funct;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= STATE_W'(S_FETCH);
      else       state_r <= STATE_W'(state_n);
   end

   assign state = state_t'(state_r[3:0]);

   alu_decoder u_alu_decoder (
      .aluop         (aluop),
      .funct3        (funct3),
      .funct7b5      (funct7b5),
      .op5           (op[5]),
      .alucontrol    (ALUControl),
      .illegal_funct (illegal_funct)
   );

   always_comb begin
      state_n    = S_FETCH;
      AdrSrc     = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      aluop      = ALUOP_ADD;
      pcupdate   = 1'b0;
      branch     = 1'b0;
      irwrite_s  = 1'b0;
      memwrite_s = 1'b0;
      regwrite_s = 1'b0;
      illegal_s  = 1'b0;
      case (state)
         S_FETCH: begin
            irwrite_s = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            pcupdate  = 1'b1;
            state_n   = S_DECODE;
         end
         S_DECODE: begin
            // PC+imm computed now so the branch target sits in ALUOut for BEQ
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_n = S_MEMADR;
               OP_R:         state_n = S_EXECR;
               OP_IALU:      state_n = S_EXECI;
               OP_BEQ:       state_n = S_BEQ;
               OP_JAL:       state_n = S_JAL;
               default: begin
                  illegal_s = ILLEGAL_TRAP;
                  state_n   = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            state_n = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc  = 1'b1;
            state_n = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = RES_READDATA;
            regwrite_s = 1'b1;
            state_n    = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc     = 1'b1;
            memwrite_s = 1'b1;
            state_n    = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcA   = SRCA_RS1;
            ALUSrcB   = (state == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
            aluop     = ALUOP_FUNCT;
            // without trapping, a bad funct decodes as add and still writes back
            illegal_s = ILLEGAL_TRAP & illegal_funct;
            state_n   = (ILLEGAL_TRAP & illegal_funct) ? S_FETCH : S_ALUWB;
         end
         S_ALUWB: begin
            regwrite_s = 1'b1;
            state_n    = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA = SRCA_RS1;
            aluop   = ALUOP_SUB;
            branch  = 1'b1;
            state_n = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA  = SRCA_OLDPC;
            ALUSrcB  = SRCB_FOUR;
            pcupdate = 1'b1;
            state_n  = S_ALUWB;
         end
         default: state_n = S_FETCH;
      endcase
   end

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = IMM_S;
         OP_BEQ:  ImmSrc = IMM_B;
         OP_JAL:  ImmSrc = IMM_J;
         default: ImmSrc = IMM_I;
      endcase
   end

   assign PCWrite  = ~reset & (pcupdate | (branch & zero));
   assign IRWrite  = ~reset & irwrite_s;
   assign MemWrite = ~reset & memwrite_s;
   assign RegWrite = ~reset & regwrite_s;
   assign illegal  = ~reset & illegal_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle output vectors are
// queued with the stimulus and compared as the controller steps through each instruction.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;

   int passed = 0;
   int total  = 0;

   // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,illegal}
   logic [16:0] obs;
   logic [16:0] sb[$];
   string       names[$];

   assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .zero       (zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .illegal    (illegal)
   );

   function automatic logic [16:0] ex(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] rs,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic ill);
      return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
   endfunction

   task automatic push(input string n, input logic [16:0] v);
      sb.push_back(v);
      names.push_back(n);
   endtask

   task automatic push_fetch(input logic [1:0] imm);
      push("fetch", ex(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0));
   endtask

   task automatic push_decode(input logic [1:0] imm, input logic ill);
      push("decode", ex(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, ill));
   endtask

   task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
   endtask

   task automatic test_reset;
      logic [16:0] e;
      string       n;
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      push("reset_hold", ex(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      e = sb.pop_front(); n = names.pop_front();
      total++;
      if (obs !== e) $display("FAIL %s: got %b expected %b", n, obs, e);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_lw;
      logic [16:0] e;
      string       n;
      set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
      push_fetch(2'b00);
      push_decode(2'b00, 0);
      push("lw_memadr", ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
      push("lw_memread", ex(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      push("lw_memwb", ex(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); n = names.pop_front();
         total++;
         if (obs !== e) $display("FAIL lw %s: got %b expected %b", n, obs, e);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw;
      logic [16:0] e;
      string       n;
      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      push_fetch(2'b01);
      push_decode(2'b01, 0);
      push("sw_memadr", ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
      push("sw_memwrite", ex(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); n = names.pop_front();
         total++;
         if (obs !== e) $display("FAIL sw %s: got %b expected %b", n, obs, e);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu_ops;
      logic [16:0] e;
      string       n;
      // op, funct3, funct7b5, expected ALUControl, EXECR vs EXECI
      logic [6:0] ops[5]  = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
      logic [2:0] f3s[5]  = '{3'b000, 3'b101, 3'b010, 3'b000, 3'b111};
      logic       f7s[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0] alus[5] = '{3'b001, 3'b100, 3'b101, 3'b000, 3'b010};
      for (int i = 0; i < 5; i++) begin
         set_instr(ops[i], f3s[i], f7s[i], 1'b0);
         push_fetch(2'b00);
         push_decode(2'b00, 0);
         push($sformatf("exec_%0d", i),
              ex(0, 0, 0, 0, 0, 2'b00, 2'b10, (ops[i] == 7'b0110011) ? 2'b00 : 2'b01,
                 2'b00, alus[i], 0));
         push($sformatf("aluwb_%0d", i), ex(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
         while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front(); n = names.pop_front();
            total++;
            if (obs !== e) $display("FAIL alu %s: got %b expected %b", n, obs, e);
            else passed++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_beq_jal;
      logic [16:0] e;
      string       n;
      for (int z = 1; z >= 0; z--) begin
         set_instr(7'b1100011, 3'b000, 1'b0, z[0]);
         push_fetch(2'b10);
         push_decode(2'b10, 0);
         push($sformatf("beq_zero%0d", z),
              ex(z[0], 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
         while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front(); n = names.pop_front();
            total++;
            if (obs !== e) $display("FAIL beq %s: got %b expected %b", n, obs, e);
            else passed++;
            @(posedge clk); #1;
         end
      end
      set_instr(7'b1101111, 3'b000, 1'b0, 1'b1);
      push_fetch(2'b11);
      push_decode(2'b11, 0);
      push("jal_state", ex(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
      push("jal_aluwb", ex(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); n = names.pop_front();
         total++;
         if (obs !== e) $display("FAIL jal %s: got %b expected %b", n, obs, e);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_illegal;
      logic [16:0] e;
      string       n;
      set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
      push_fetch(2'b00);
      push_decode(2'b00, 1);
      push_fetch(2'b00);
      push_decode(2'b00, 1);
      // illegal I-ALU funct: trap in EXECI, then straight back to fetch with no write-back
      push("ialu_fetch", ex(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      push("ialu_decode", ex(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
      push("ialu_execi_bad", ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1));
      push("ialu_refetch", ex(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); n = names.pop_front();
         total++;
         if (obs !== e) $display("FAIL illegal %s: got %b expected %b", n, obs, e);
         else passed++;
         @(posedge clk); #1;
         if (sb.size() == 4) set_instr(7'b0010011, 3'b001, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset_mid_sw;
      logic [16:0] e;
      string       n;
      // fetch state left over from the illegal test's refetch cycle is now decode
      set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
      reset = 1'b1; #1; reset = 1'b0;
      push_fetch(2'b01);
      push_decode(2'b01, 0);
      push("rst_memadr", ex(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); n = names.pop_front();
         total++;
         if (obs !== e) $display("FAIL rstsw %s: got %b expected %b", n, obs, e);
         else passed++;
         @(posedge clk); #1;
      end
      total++;
      if (MemWrite !== 1'b1) $display("FAIL rstsw memwrite_before: got %b expected 1", MemWrite);
      else passed++;
      reset = 1'b1;
      #1;
      push("rst_async", ex(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
      e = sb.pop_front(); n = names.pop_front();
      total++;
      if (obs !== e) $display("FAIL rstsw %s: got %b expected %b", n, obs, e);
      else passed++;
      @(posedge clk); #1;
      reset = 1'b0;
      push_fetch(2'b01);
      push_decode(2'b01, 0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front(); n = names.pop_front();
         total++;
         if (obs !== e) $display("FAIL rstsw after_%s: got %b expected %b", n, obs, e);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_alu_ops();
      test_beq_jal();
      test_illegal();
      test_reset_mid_sw();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
